// File: rtl/cpu_run_if.sv
// Handshake bundle between the bench/debug front-end (master) and the
// run controller (slave).
interface cpu_run_if #(
    parameter int CYC_W = 16
) ();
    logic             i_start;
    logic             i_step_mode;
    logic             i_step;
    logic             i_pause;
    logic             i_abort;
    logic [31:0]      i_instr;
    logic             o_cpu_clr;
    logic             o_cpu_en;
    logic             o_done;
    logic [1:0]       o_halt_cause;
    logic [CYC_W-1:0] o_cycle;

    modport master (
        output i_start, i_step_mode, i_step, i_pause, i_abort, i_instr,
        input  o_cpu_clr, o_cpu_en, o_done, o_halt_cause, o_cycle
    );

    modport slave (
        input  i_start, i_step_mode, i_step, i_pause, i_abort, i_instr,
        output o_cpu_clr, o_cpu_en, o_done, o_halt_cause, o_cycle
    );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/step sequencer for the single-cycle core: gates the commit enable,
// clears the datapath at start, stops on ECALL/EBREAK, watchdog or abort.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for start
// CLR       | one-cycle datapath clear
// RUN       | free run, one commit per cycle unless paused/stopped
// STEP_WAIT | single-step mode, waiting for a rising edge on i_step
// STEP_EXEC | single-step mode, commit exactly one instruction
// DONE      | stopped; done, cause and count held until next start
module cpu_run_controller #(
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic     clk,
    input  logic     a_reset_n,
    cpu_run_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR       = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        STEP_EXEC = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_HALT  = 2'b01;
    localparam logic [1:0] CAUSE_TOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ABORT = 2'b11;

    state_t           state_q;
    logic             clr_q;
    logic             done_q;
    logic [1:0]       cause_q;
    logic [CYC_W-1:0] cycle_q;
    logic             step_q;

    logic       halt_insn;
    logic       timeout;
    logic       exec_state;
    logic       stop_exec;
    logic [1:0] stop_cause;
    logic       step_rise;
    logic       cpu_en;

    // Stop/commit decode; the enable must react within the current cycle.
    always_comb begin
        halt_insn  = (bus.i_instr == 32'h0000_0073) || (bus.i_instr == 32'h0010_0073);
        timeout    = (cycle_q == CYC_W'(MAX_CYCLES));
        exec_state = (state_q == RUN) || (state_q == STEP_EXEC);
        stop_exec  = bus.i_abort || halt_insn || timeout;
        stop_cause = bus.i_abort ? CAUSE_ABORT : (halt_insn ? CAUSE_HALT : CAUSE_TOUT);
        step_rise  = bus.i_step && !step_q;
        cpu_en     = exec_state && !stop_exec && !bus.i_pause;
    end

    // Sequencer state, counter and registered status outputs.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            cycle_q <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= bus.i_step;
            clr_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        state_q <= CLR;
                        clr_q   <= 1'b1;
                        cycle_q <= '0;
                        done_q  <= 1'b0;
                        cause_q <= CAUSE_NONE;
                    end
                end
                CLR: begin
                    if (bus.i_abort) begin
                        state_q <= DONE;
                        cause_q <= CAUSE_ABORT;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= bus.i_step_mode ? STEP_WAIT : RUN;
                    end
                end
                RUN, STEP_EXEC: begin
                    if (stop_exec) begin
                        state_q <= DONE;
                        cause_q <= stop_cause;
                        done_q  <= 1'b1;
                    end else if (cpu_en) begin
                        // A paused cycle holds both the count and the state.
                        cycle_q <= cycle_q + 1'b1;
                        if (state_q == STEP_EXEC || bus.i_step_mode) begin
                            state_q <= STEP_WAIT;
                        end
                    end
                end
                STEP_WAIT: begin
                    if (bus.i_abort) begin
                        state_q <= DONE;
                        cause_q <= CAUSE_ABORT;
                        done_q  <= 1'b1;
                    end else if (step_rise) begin
                        state_q <= STEP_EXEC;
                    end else if (!bus.i_step_mode) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_cpu_clr    = clr_q;
    assign bus.o_cpu_en     = cpu_en;
    assign bus.o_done       = done_q;
    assign bus.o_halt_cause = cause_q;
    assign bus.o_cycle      = cycle_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a tiny instruction memory follows the commit
// enable like the core's PC would; expectations go through a queue.
module tb_cpu_run_controller;
    localparam int          CYC_W = 16;
    localparam int          MAXC  = 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic a_reset_n;
    always #5 clk = ~clk;

    cpu_run_if #(.CYC_W(CYC_W)) bus ();

    cpu_run_controller #(.CYC_W(CYC_W), .MAX_CYCLES(MAXC)) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .bus       (bus)
    );

    logic [31:0] prog [0:15];
    int          pc;
    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    int          clr_cnt = 0;
    exp_t        sb[$];

    assign bus.i_instr = (pc < 16) ? prog[pc] : NOP;

    // Program counter model: cleared by o_cpu_clr, advanced on each commit.
    always @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n)           pc <= 0;
        else if (bus.o_cpu_clr)   pc <= 0;
        else if (bus.o_cpu_en)    pc <= pc + 1;
    end

    // Count enable and clear cycles away from the active edge.
    always @(negedge clk) begin
        if (a_reset_n) begin
            if (bus.o_cpu_en)  en_cnt++;
            if (bus.o_cpu_clr) clr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.o_done && n < budget) begin
            tick();
            n++;
        end
        if (!bus.o_done) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cycle(input int v, input int budget);
        int n = 0;
        while (int'(bus.o_cycle) != v && n < budget) begin
            tick();
            n++;
        end
        if (int'(bus.o_cycle) != v) check("wait_cycle_timeout", 32'(bus.o_cycle), 32'(v));
    endtask

    task automatic fill_prog(input logic [31:0] w);
        for (int i = 0; i < 16; i++) prog[i] = w;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int e0;
        int c0;
        bus.i_start     = 1'b0;
        bus.i_step_mode = 1'b0;
        bus.i_step      = 1'b0;
        bus.i_pause     = 1'b0;
        bus.i_abort     = 1'b0;
        fill_prog(NOP);
        a_reset_n = 1'b0;
        #3;
        sb_push("rst_en", 0);    sb_check(32'(bus.o_cpu_en));
        sb_push("rst_clr", 0);   sb_check(32'(bus.o_cpu_clr));
        sb_push("rst_done", 0);  sb_check(32'(bus.o_done));
        sb_push("rst_cause", 0); sb_check(32'(bus.o_halt_cause));
        sb_push("rst_cycle", 0); sb_check(32'(bus.o_cycle));
        @(negedge clk);
        a_reset_n = 1'b1;
        tick();

        // T1: five NOPs then ECALL
        for (int i = 0; i < 5; i++) prog[i] = NOP;
        prog[5] = ECALL;
        e0 = en_cnt; c0 = clr_cnt;
        sb_push("t1_en_cnt", 5);
        sb_push("t1_clr_cnt", 1);
        sb_push("t1_cycle", 5);
        sb_push("t1_done", 1);
        sb_push("t1_cause", 1);
        start_run();
        wait_done(40);
        sb_check(32'(en_cnt - e0));
        sb_check(32'(clr_cnt - c0));
        sb_check(32'(bus.o_cycle));
        sb_check(32'(bus.o_done));
        sb_check(32'(bus.o_halt_cause));
        e0 = en_cnt;
        sb_push("t1_hold_en", 0);
        sb_push("t1_hold_cycle", 5);
        repeat (3) tick();
        sb_check(32'(en_cnt - e0));
        sb_check(32'(bus.o_cycle));

        // T2: NOP stream runs into the watchdog
        fill_prog(NOP);
        e0 = en_cnt;
        sb_push("t2_en_cnt", MAXC);
        sb_push("t2_cycle", MAXC);
        sb_push("t2_cause", 2);
        sb_push("t2_done", 1);
        start_run();
        wait_done(60);
        sb_check(32'(en_cnt - e0));
        sb_check(32'(bus.o_cycle));
        sb_check(32'(bus.o_halt_cause));
        sb_check(32'(bus.o_done));

        // T3: single-step, three pulses each held four clocks, then abort
        bus.i_step_mode = 1'b1;
        e0 = en_cnt;
        start_run();
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.i_step = 1'b1;
            repeat (4) tick();
            bus.i_step = 1'b0;
            repeat (2) tick();
        end
        sb_push("t3_en_cnt", 3);
        sb_push("t3_cycle", 3);
        sb_push("t3_done", 0);
        sb_check(32'(en_cnt - e0));
        sb_check(32'(bus.o_cycle));
        sb_check(32'(bus.o_done));
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        sb_push("t3_abort_cause", 3);
        sb_push("t3_abort_done", 1);
        sb_push("t3_abort_cycle", 3);
        sb_check(32'(bus.o_halt_cause));
        sb_check(32'(bus.o_done));
        sb_check(32'(bus.o_cycle));
        bus.i_step_mode = 1'b0;

        // T4: pause for two clocks after three instructions
        e0 = en_cnt;
        start_run();
        wait_cycle(3, 20);
        bus.i_pause = 1'b1;
        repeat (2) begin
            sb_push("t4_pause_en", 0);
            sb_push("t4_pause_cycle", 3);
            @(negedge clk);
            sb_check(32'(bus.o_cpu_en));
            sb_check(32'(bus.o_cycle));
            tick();
        end
        bus.i_pause = 1'b0;
        sb_push("t4_resume_en", 1);
        @(negedge clk);
        sb_check(32'(bus.o_cpu_en));
        sb_push("t4_en_cnt", MAXC);
        sb_push("t4_cycle", MAXC);
        sb_push("t4_cause", 2);
        wait_done(40);
        sb_check(32'(en_cnt - e0));
        sb_check(32'(bus.o_cycle));
        sb_check(32'(bus.o_halt_cause));

        // T5: abort and ECALL in the same cycle, then restart
        fill_prog(NOP);
        prog[2] = ECALL;
        start_run();
        wait_cycle(2, 20);
        bus.i_abort = 1'b1;
        sb_push("t5_en", 0);
        @(negedge clk);
        sb_check(32'(bus.o_cpu_en));
        tick();
        bus.i_abort = 1'b0;
        sb_push("t5_cause", 3);
        sb_push("t5_done", 1);
        sb_push("t5_cycle", 2);
        sb_check(32'(bus.o_halt_cause));
        sb_check(32'(bus.o_done));
        sb_check(32'(bus.o_cycle));
        start_run();
        sb_push("t5_restart_done", 0);
        sb_push("t5_restart_cycle", 0);
        sb_push("t5_restart_cause", 0);
        sb_check(32'(bus.o_done));
        sb_check(32'(bus.o_cycle));
        sb_check(32'(bus.o_halt_cause));
        sb_push("t5_rerun_cause", 1);
        sb_push("t5_rerun_cycle", 2);
        wait_done(40);
        sb_check(32'(bus.o_halt_cause));
        sb_check(32'(bus.o_cycle));

        // T6: asynchronous reset mid-run
        fill_prog(NOP);
        start_run();
        wait_cycle(2, 20);
        #2;
        a_reset_n = 1'b0;
        #1;
        sb_push("t6_en", 0);
        sb_push("t6_clr", 0);
        sb_push("t6_done", 0);
        sb_push("t6_cause", 0);
        sb_push("t6_cycle", 0);
        sb_check(32'(bus.o_cpu_en));
        sb_check(32'(bus.o_cpu_clr));
        sb_check(32'(bus.o_done));
        sb_check(32'(bus.o_halt_cause));
        sb_check(32'(bus.o_cycle));
        #10;
        @(negedge clk);
        a_reset_n = 1'b1;
        e0 = en_cnt;
        repeat (3) tick();
        sb_push("t6_idle_en_cnt", 0);
        sb_push("t6_idle_cycle", 0);
        sb_push("t6_idle_clr", 0);
        sb_check(32'(en_cnt - e0));
        sb_check(32'(bus.o_cycle));
        sb_check(32'(bus.o_cpu_clr));

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
